io_slave_responder: RTL and testbench

//  Target-side responder for the classic cyc/stb/ack I/O bus driven by the I/O bridge master port.

---
 rtl/io_slave_responder.sv | 182 ++++++++++++++++++
 tb/tb_io_slave_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/io_slave_responder.sv
// Target-side responder for the cyc/stb/ack I/O bus: one address window, NREG byte-writable registers.
// Optional err_o response for out-of-range register offsets when IO_RESP_ERR_EN is defined.
module io_slave_responder #(
   parameter logic [31:0] BASE  = 32'hFD0C0000,
   parameter int unsigned ABITS = 8,
   parameter int unsigned NREG  = 16,
   parameter int unsigned WAIT  = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cyc_i,
   input  logic                      stb_i,
   input  logic                      we_i,
   input  logic [3:0]                sel_i,
   input  logic [31:0]               adr_i,
   input  logic [31:0]               dat_i,
   output logic                      ack_o,
   output logic                      stall_o,
   output logic                      err_o,
   output logic [31:0]               dat_o,
   output logic [NREG*32-1:0]        reg_o,
   output logic                      wr_o,
   output logic [$clog2(NREG)-1:0]   wr_idx_o
);

   localparam int unsigned IXW = ABITS - 2;
   localparam int unsigned IW  = $clog2(NREG);
   localparam logic [IXW:0] NREG_L = (IXW+1)'(NREG);

`ifdef IO_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, WAIT_ST, RESP, HOLD} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q;
   logic             we_q;
   logic [3:0]       sel_q;
   logic [IXW-1:0]   idx_q;
   logic [31:0]      wdat_q;
   logic [31:0]      regs_q [NREG];

   logic             ack_q, ack_d;
   logic             stall_q, stall_d;
   logic             err_q, err_d;
   logic [31:0]      dat_q, dat_d;
   logic             wr_q, wr_d;
   logic [IW-1:0]    wr_idx_q, wr_idx_d;
   logic             commit;

   logic             cs, in_range;
   logic [31:0]      rdata;
   logic             unused_adr_lsb;

   assign cs             = cyc_i & stb_i & (adr_i[31:ABITS] == BASE[31:ABITS]);
   assign in_range       = ({1'b0, idx_q} < NREG_L);
   assign unused_adr_lsb = ^adr_i[1:0];

   always_comb begin
      rdata = '0;
      if (in_range) rdata = regs_q[idx_q[IW-1:0]];
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; abort in WAIT_ST takes priority over the cnt==0 exit
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cs) state_d = WAIT_ST;
         WAIT_ST: begin
            if (!(cyc_i && stb_i)) state_d = IDLE;
            else if (cnt_q == 4'd0) state_d = RESP;
         end
         RESP:    state_d = HOLD;
         HOLD:    if (!stb_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next-values
   always_comb begin
      stall_d  = stall_q;
      ack_d    = ack_q;
      err_d    = err_q;
      dat_d    = dat_q;
      wr_d     = 1'b0;
      wr_idx_d = wr_idx_q;
      commit   = 1'b0;
      unique case (state_q)
         IDLE:    if (cs) stall_d = 1'b1;
         WAIT_ST: if (!(cyc_i && stb_i)) stall_d = 1'b0;
         RESP: begin
            if (ERR_EN && !in_range) begin
               err_d = 1'b1;
               dat_d = '0;
            end else begin
               ack_d = 1'b1;
               if (we_q) begin
                  dat_d = '0;
                  if (in_range) begin
                     commit   = 1'b1;
                     wr_d     = 1'b1;
                     wr_idx_d = idx_q[IW-1:0];
                  end
               end else begin
                  dat_d = rdata;
               end
            end
         end
         HOLD: begin
            if (!stb_i) begin
               ack_d   = 1'b0;
               err_d   = 1'b0;
               dat_d   = '0;
               stall_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ack_q    <= 1'b0;
         stall_q  <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
         wr_q     <= 1'b0;
         wr_idx_q <= '0;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         idx_q    <= '0;
         wdat_q   <= '0;
      end else begin
         ack_q    <= ack_d;
         stall_q  <= stall_d;
         err_q    <= err_d;
         dat_q    <= dat_d;
         wr_q     <= wr_d;
         wr_idx_q <= wr_idx_d;
         if (state_q == IDLE && cs) begin
            cnt_q  <= 4'(WAIT);
            we_q   <= we_i;
            sel_q  <= sel_i;
            idx_q  <= adr_i[ABITS-1:2];
            wdat_q <= dat_i;
         end else if (state_q == WAIT_ST && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int unsigned n = 0; n < NREG; n++) regs_q[n] <= '0;
      end else if (commit) begin
         for (int unsigned k = 0; k < 4; k++)
            if (sel_q[k]) regs_q[idx_q[IW-1:0]][8*k +: 8] <= wdat_q[8*k +: 8];
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_reg_out
      assign reg_o[g*32 +: 32] = regs_q[g];
   end

   assign ack_o    = ack_q;
   assign stall_o  = stall_q;
   assign err_o    = err_q;
   assign dat_o    = dat_q;
   assign wr_o     = wr_q;
   assign wr_idx_o = wr_idx_q;

endmodule

// File: tb/tb_io_slave_responder.sv
// Randomized self-checking bench for io_slave_responder against a transaction-level register model.
// Expectations follow IO_RESP_ERR_EN the same way the design build does.
module tb_io_slave_responder;

   localparam logic [31:0] BASE  = 32'hFD0C0000;
   localparam int unsigned ABITS = 8;
   localparam int unsigned NREG  = 16;
   localparam int unsigned WAIT  = 2;
   localparam int unsigned IW    = $clog2(NREG);

`ifdef IO_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                cyc = 1'b0;
   logic                stb = 1'b0;
   logic                we  = 1'b0;
   logic [3:0]          sel = '0;
   logic [31:0]         adr = '0;
   logic [31:0]         wdat = '0;
   logic                ack_o, stall_o, err_o, wr_o;
   logic [31:0]         dat_o;
   logic [NREG*32-1:0]  reg_o;
   logic [IW-1:0]       wr_idx_o;

   io_slave_responder #(.BASE(BASE), .ABITS(ABITS), .NREG(NREG), .WAIT(WAIT)) dut (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel),
      .adr_i(adr), .dat_i(wdat), .ack_o(ack_o), .stall_o(stall_o), .err_o(err_o),
      .dat_o(dat_o), .reg_o(reg_o), .wr_o(wr_o), .wr_idx_o(wr_idx_o)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model [NREG];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int n = 0; n < NREG; n++) check(tag, reg_o[n*32 +: 32], model[n]);
   endtask

   task automatic scramble_bus();
      adr  = $urandom;
      we   = 1'($urandom);
      sel  = 4'($urandom);
      wdat = $urandom;
   endtask

   // Full transaction: request, wait for response, hold, release (or reset during hold)
   task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input int hold, input bit rst_in_hold);
      int          idx;
      bit          inr, errx;
      int          n;
      logic [31:0] exp_dat;
      idx  = int'(a[ABITS-1:2]);
      inr  = (idx < NREG);
      errx = ERR_EN && !inr;
      exp_dat = (w || !inr) ? 32'h0 : model[idx];
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; adr = a; we = w; sel = s; wdat = d;
      @(negedge clk);
      n = 1;
      check("stall_after_capture", stall_o, 1);
      scramble_bus();
      while (ack_o !== 1'b1 && err_o !== 1'b1 && n < WAIT + 12) begin
         check("no_early_resp", ack_o | err_o, 0);
         @(negedge clk);
         n++;
         scramble_bus();
      end
      check("latency", n - 1, WAIT + 2);
      check("ack", ack_o, !errx);
      check("err", err_o, errx);
      check("rdata", dat_o, exp_dat);
      check("wr_pulse", wr_o, w && inr && !errx);
      if (w && inr) begin
         check("wr_idx", wr_idx_o, idx);
         for (int k = 0; k < 4; k++)
            if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      end
      if (rst_in_hold) begin
         rst = 1'b0;
         @(negedge clk);
         for (int r = 0; r < NREG; r++) model[r] = '0;
         check("rst_ack", ack_o, 0);
         check("rst_err", err_o, 0);
         check("rst_stall", stall_o, 0);
         check("rst_dat", dat_o, 0);
         check("rst_wr_idx", wr_idx_o, 0);
         check_regs("rst_regs");
         rst = 1'b1; cyc = 1'b0; stb = 1'b0;
         return;
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_ack", ack_o, !errx);
         check("hold_err", err_o, errx);
         check("hold_dat", dat_o, exp_dat);
         check("wr_one_cycle", wr_o, 0);
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check("rel_ack", ack_o, 0);
      check("rel_err", err_o, 0);
      check("rel_dat", dat_o, 0);
      check("rel_stall", stall_o, 0);
      check("rel_wr", wr_o, 0);
      check_regs("regs");
   endtask

   // Request that drops stb after j+1 cycles of waiting (j in 0..WAIT)
   task automatic abort_access(input logic [31:0] a, input logic [31:0] d, input int j);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; adr = a; we = 1'b1; sel = 4'hF; wdat = d;
      for (int i = 0; i <= j; i++) begin
         @(negedge clk);
         check("abort_stall", stall_o, 1);
         check("abort_noack", ack_o, 0);
      end
      stb = 1'b0;
      if ($urandom_range(0, 1) == 0) cyc = 1'b0;
      @(negedge clk);
      cyc = 1'b0;
      check("abort_stall_clr", stall_o, 0);
      for (int i = 0; i < 3; i++) begin
         check("abort_ack", ack_o | err_o, 0);
         check("abort_wr", wr_o, 0);
         @(negedge clk);
      end
      check_regs("abort_regs");
   endtask

   // Request the device must ignore (outside window, or cyc low)
   task automatic ignored_access(input logic [31:0] a, input logic c);
      @(negedge clk);
      cyc = c; stb = 1'b1; adr = a; we = 1'($urandom); sel = 4'hF; wdat = $urandom;
      for (int i = 0; i < WAIT + 4; i++) begin
         @(negedge clk);
         check("ign_ack", ack_o | err_o, 0);
         check("ign_stall", stall_o, 0);
         check("ign_wr", wr_o, 0);
      end
      cyc = 1'b0; stb = 1'b0;
      check_regs("ign_regs");
   endtask

   function automatic logic [31:0] rand_adr();
      logic [31:0] idx;
      if ($urandom_range(0, 4) == 0) idx = 32'($urandom_range(NREG, (1 << (ABITS - 2)) - 1));
      else                           idx = 32'($urandom_range(0, NREG - 1));
      return BASE | (idx << 2) | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int          r;
      for (int i = 0; i < NREG; i++) model[i] = '0;
      repeat (3) @(negedge clk);
      check("reset_ack", ack_o, 0);
      check("reset_stall", stall_o, 0);
      check("reset_err", err_o, 0);
      check("reset_dat", dat_o, 0);
      check("reset_wr", wr_o, 0);
      check("reset_wr_idx", wr_idx_o, 0);
      check_regs("reset_regs");
      rst = 1'b1;

      access(BASE + 32'd4, 1'b1, 4'hF, 32'hDEADBEEF, 1, 1'b0);
      check("t1_reg1", reg_o[63:32], 32'hDEADBEEF);
      access(BASE + 32'd4, 1'b0, 4'hF, 32'h0, 2, 1'b0);
      access(BASE + 32'd4, 1'b1, 4'b0101, 32'h11223344, 0, 1'b0);
      check("t3_reg1", reg_o[63:32], 32'hDE22BE44);
      access(BASE + 32'd8, 1'b1, 4'hF, 32'hCAFEF00D, 0, 1'b0);
      for (int j = 0; j <= WAIT; j++) abort_access(BASE + 32'd8, 32'h55555555, j);
      check("t4_reg2", reg_o[95:64], 32'hCAFEF00D);
      access(BASE + NREG * 4, 1'b0, 4'hF, 32'h0, 1, 1'b0);
      access(BASE + NREG * 4 + 32'd8, 1'b1, 4'hF, 32'hFFFFFFFF, 1, 1'b0);
      access(BASE + 32'd12, 1'b1, 4'h0, 32'h12345678, 1, 1'b0);
      access(BASE + 32'd12, 1'b0, 4'hF, 32'h0, 1, 1'b1);
      ignored_access(BASE + (32'd1 << ABITS), 1'b1);
      ignored_access(BASE - 32'd4, 1'b1);
      ignored_access(BASE + 32'd4, 1'b0);

      for (int t = 0; t < 400; t++) begin
         r = $urandom_range(0, 39);
         a = rand_adr();
         if (r < 3)       abort_access(a, $urandom, $urandom_range(0, WAIT));
         else if (r < 5)  ignored_access({~BASE[31:ABITS], a[ABITS-1:0]}, 1'b1);
         else if (r == 5) access(a, 1'($urandom), 4'($urandom), $urandom, 0, 1'b1);
         else             access(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
